// File: rtl/amba3_axi_mem_slave_pkg.sv
// Shared AXI3 burst/response encodings, FSM state types and burst legality check
// for the memory-backed AXI slave.
package pkg_amba3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // A burst is illegal for a reserved type, a beat wider than the bus,
    // or a wrap whose length is not 2, 4, 8 or 16 beats.
    function automatic logic burst_legal(input logic [1:0]  burst,
                                         input logic [3:0]  len,
                                         input logic [2:0]  size,
                                         input int unsigned lsb);
        logic ok;
        ok = (burst != BURST_RSVD) && (32'(size) <= lsb);
        if (burst == BURST_WRAP)
            ok = ok && ((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return ok;
    endfunction

endpackage

// File: rtl/amba3_axi_burst_addr.sv
// Combinational AXI3 beat-address generator: next beat address, last-beat flag
// and burst legality for the burst currently held by the caller.
module amba3_axi_burst_addr
    import pkg_amba3::*;
#(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LSB       = 4
)(
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [3:0]           i_len,
    input  logic [2:0]           i_size,
    input  logic [1:0]           i_burst,
    input  logic [3:0]           i_beat,
    output logic [ADDR_SIZE-1:0] o_next_addr,
    output logic                 o_last,
    output logic                 o_illegal
);

    logic [ADDR_SIZE-1:0] w_incr;
    logic [ADDR_SIZE-1:0] w_mask;
    logic [ADDR_SIZE-1:0] w_sum;

    always_comb begin
        w_incr = ADDR_SIZE'(1) << i_size;
        // Wrap window is (len+1) beats of 2**size bytes, aligned to its own size.
        w_mask = ((ADDR_SIZE'(i_len) + ADDR_SIZE'(1)) << i_size) - ADDR_SIZE'(1);
        w_sum  = i_addr + w_incr;
        case (burst_e'(i_burst))
            BURST_INCR: o_next_addr = w_sum;
            BURST_WRAP: o_next_addr = (i_addr & ~w_mask) | (w_sum & w_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

    assign o_last    = (i_beat == i_len);
    assign o_illegal = !burst_legal(i_burst, i_len, i_size, LSB);

endmodule

// File: rtl/amba3_axi_mem_slave.sv
// AXI3 slave backed by a byte-enabled on-chip word memory; independent write
// (AW/W/B) and read (AR/R) state machines sharing only the storage array.
module amba3_axi_mem_slave
    import pkg_amba3::*;
#(
    parameter int unsigned TXID_SIZE  = 4,
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned DATA_SIZE  = 128,
    parameter int unsigned DEPTH_LOG2 = 10
)(
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [TXID_SIZE-1:0]   awid,
    input  logic [ADDR_SIZE-1:0]   awaddr,
    input  logic [3:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [TXID_SIZE-1:0]   wid,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [TXID_SIZE-1:0]   bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [TXID_SIZE-1:0]   arid,
    input  logic [ADDR_SIZE-1:0]   araddr,
    input  logic [3:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [TXID_SIZE-1:0]   rid,
    output logic [DATA_SIZE-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int unsigned LSB    = $clog2(DATA_SIZE / 8);
    localparam int unsigned NBYTES = DATA_SIZE / 8;
    localparam int unsigned WORDS  = 1 << DEPTH_LOG2;

    logic [DATA_SIZE-1:0] r_mem [WORDS];

    // ---------------- write channel ----------------
    wr_state_e             r_wstate, w_wstate_nxt;
    logic [TXID_SIZE-1:0]  r_aw_id;
    logic [ADDR_SIZE-1:0]  r_aw_addr;
    logic [3:0]            r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic [3:0]            r_aw_beat;
    logic                  r_w_err;
    logic [ADDR_SIZE-1:0]  w_aw_next;
    logic                  w_aw_last;
    logic                  w_aw_illegal;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [DEPTH_LOG2-1:0] w_w_idx;

    amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE), .LSB(LSB)) u_wr_addr (
        .i_addr      (r_aw_addr),
        .i_len       (r_aw_len),
        .i_size      (r_aw_size),
        .i_burst     (r_aw_burst),
        .i_beat      (r_aw_beat),
        .o_next_addr (w_aw_next),
        .o_last      (w_aw_last),
        .o_illegal   (w_aw_illegal)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_wstate <= W_IDLE;
        else           r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_aw_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_w_idx = r_aw_addr[LSB +: DEPTH_LOG2];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_aw_beat  <= '0;
            r_w_err    <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_id    <= awid;
            r_aw_addr  <= awaddr;
            r_aw_len   <= awlen;
            r_aw_size  <= awsize;
            r_aw_burst <= awburst;
            r_aw_beat  <= '0;
            r_w_err    <= 1'b0;
        end else if (w_w_hs) begin
            r_aw_addr <= w_aw_next;
            r_aw_beat <= r_aw_beat + 4'd1;
            // The burst length is governed by awlen; a wrong wlast or wid only taints the response.
            if ((wid != r_aw_id) || (wlast != w_aw_last)) r_w_err <= 1'b1;
        end
    end

    assign bid   = r_aw_id;
    assign bresp = (w_aw_illegal || r_w_err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (w_w_hs && !w_aw_illegal) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wstrb[i]) r_mem[w_w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_e             r_rstate, w_rstate_nxt;
    logic [TXID_SIZE-1:0]  r_ar_id;
    logic [ADDR_SIZE-1:0]  r_ar_addr;
    logic [3:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic [3:0]            r_ar_beat;
    logic [DATA_SIZE-1:0]  r_rdata;
    logic [ADDR_SIZE-1:0]  w_ar_next;
    logic                  w_ar_last;
    logic                  w_ar_illegal;
    logic                  w_ar_in_illegal;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [DEPTH_LOG2-1:0] w_ar_in_idx;
    logic [DEPTH_LOG2-1:0] w_ar_next_idx;

    amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE), .LSB(LSB)) u_rd_addr (
        .i_addr      (r_ar_addr),
        .i_len       (r_ar_len),
        .i_size      (r_ar_size),
        .i_burst     (r_ar_burst),
        .i_beat      (r_ar_beat),
        .o_next_addr (w_ar_next),
        .o_last      (w_ar_last),
        .o_illegal   (w_ar_illegal)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_rstate <= R_IDLE;
        else           r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rlast        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = w_ar_last;
                if (rready && w_ar_last) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs         = arvalid && arready;
    assign w_r_hs          = rvalid && rready;
    assign w_ar_in_illegal = !burst_legal(arburst, arlen, arsize, LSB);
    assign w_ar_in_idx     = araddr[LSB +: DEPTH_LOG2];
    assign w_ar_next_idx   = w_ar_next[LSB +: DEPTH_LOG2];

    // First beat is fetched on the AR edge and each following beat on the
    // accepting R edge, so a continuously ready master sees no bubbles.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_ar_beat  <= '0;
            r_rdata    <= '0;
        end else if (w_ar_hs) begin
            r_ar_id    <= arid;
            r_ar_addr  <= araddr;
            r_ar_len   <= arlen;
            r_ar_size  <= arsize;
            r_ar_burst <= arburst;
            r_ar_beat  <= '0;
            r_rdata    <= w_ar_in_illegal ? '0 : r_mem[w_ar_in_idx];
        end else if (w_r_hs && !w_ar_last) begin
            r_ar_addr <= w_ar_next;
            r_ar_beat <= r_ar_beat + 4'd1;
            r_rdata   <= w_ar_illegal ? '0 : r_mem[w_ar_next_idx];
        end
    end

    assign rid   = r_ar_id;
    assign rdata = r_rdata;
    assign rresp = w_ar_illegal ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_amba3_axi_mem_slave.sv
// Directed self-checking bench for amba3_axi_mem_slave (default parameters:
// 4-bit IDs, 32-bit address, 128-bit data, 1024 words).
module tb_amba3_axi_mem_slave;

    logic         aclk = 1'b0;
    logic         areset_n = 1'b1;
    logic [3:0]   awid = '0;
    logic [31:0]  awaddr = '0;
    logic [3:0]   awlen = '0;
    logic [2:0]   awsize = '0;
    logic [1:0]   awburst = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [3:0]   wid = '0;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wlast = 1'b0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [3:0]   arid = '0;
    logic [31:0]  araddr = '0;
    logic [3:0]   arlen = '0;
    logic [2:0]   arsize = '0;
    logic [1:0]   arburst = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [3:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready = 1'b0;

    always #5 aclk = ~aclk;

    amba3_axi_mem_slave #(
        .TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128), .DEPTH_LOG2(10)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] wd [16];
    logic [15:0]  ws [16];
    logic [127:0] rd [16];
    logic [1:0]   rr [16];
    logic         rl [16];
    logic [3:0]   rid_cap;
    logic [3:0]   bid_cap;
    logic [1:0]   bresp_cap;
    logic         stable_ok;

    // Both drivers are entered and left #1 after a rising edge.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int bad_wid_beat, input int early_last_beat);
        int n;
        bit tmo;
        tmo = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo = 1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wid    = (b == bad_wid_beat) ? (id ^ 4'h1) : id;
            wdata  = wd[b];
            wstrb  = ws[b];
            wlast  = (b == int'(len)) || (b == early_last_beat);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 200) begin @(posedge aclk); #1; n++; end
            if (n >= 200) tmo = 1;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo = 1;
        bresp_cap = bresp; bid_cap = bid;
        @(posedge aclk); #1;
        bready = 1'b0;
        checks++;
        if (tmo) begin errors++; $display("FAIL write_handshake: got timeout expected completion addr=%h", addr); end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n;
        int got;
        bit stall_prev;
        logic [127:0] prev;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        got = 0; stall_prev = 0; stable_ok = 1'b1; prev = '0;
        while (got <= int'(len) && n < 400) begin
            rready = toggle ? ((n % 2) == 0) : 1'b1;
            if (stall_prev && rdata !== prev) stable_ok = 1'b0;
            if (rvalid && rready) begin
                rd[got] = rdata; rr[got] = rresp; rl[got] = rlast; rid_cap = rid;
                got++;
            end
            stall_prev = rvalid && !rready;
            prev = rdata;
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        checks++;
        if (got != int'(len) + 1) begin
            errors++; $display("FAIL read_beats: got %0d expected %0d addr=%h", got, int'(len) + 1, addr);
        end
    endtask

    task automatic fill_words(input logic [31:0] addr, input logic [31:0] base);
        for (int b = 0; b < 4; b++) begin wd[b] = 128'(base + 32'(b)); ws[b] = '1; end
        axi_write(4'h0, addr, 4'd3, 3'd4, 2'b01, -1, -1);
    endtask

    task automatic test_reset;
        areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            errors++; $display("FAIL reset_flags: got %b expected 110000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp}); end
        checks++;
        if ({bid, rid} !== 8'h00) begin errors++; $display("FAIL reset_ids: got %h expected 00", {bid, rid}); end
        checks++;
        if (rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        areset_n = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_incr;
        for (int b = 0; b < 4; b++) begin wd[b] = 128'(32'h11 + b); ws[b] = '1; end
        axi_write(4'h3, 32'h10, 4'd3, 3'd4, 2'b01, -1, -1);
        checks++;
        if (bresp_cap !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b expected 00", bresp_cap); end
        checks++;
        if (bid_cap !== 4'h3) begin errors++; $display("FAIL incr_bid: got %h expected 3", bid_cap); end
        axi_read(4'h5, 32'h10, 4'd3, 3'd4, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== 128'(32'h11 + b) || rl[b] !== (b == 3) || rr[b] !== 2'b00) begin
                errors++;
                $display("FAIL incr_rbeat[%0d]: got data=%h last=%b resp=%b expected data=%h last=%b resp=00",
                         b, rd[b], rl[b], rr[b], 128'(32'h11 + b), (b == 3));
            end
        end
        checks++;
        if (rid_cap !== 4'h5) begin errors++; $display("FAIL incr_rid: got %h expected 5", rid_cap); end
        checks++;
        if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL incr_read_end: got %b expected 01", {rvalid, arready}); end
    endtask

    task automatic test_wrap;
        logic [127:0] exp [4];
        exp[0] = 128'h23; exp[1] = 128'h24; exp[2] = 128'h21; exp[3] = 128'h22;
        for (int b = 0; b < 4; b++) begin wd[b] = 128'(32'h21 + b); ws[b] = '1; end
        axi_write(4'h1, 32'h28, 4'd3, 3'd4, 2'b10, -1, -1);
        checks++;
        if (bresp_cap !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b expected 00", bresp_cap); end
        axi_read(4'h1, 32'h00, 4'd3, 3'd4, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== exp[b]) begin errors++; $display("FAIL wrap_word[%0d]: got %h expected %h", b, rd[b], exp[b]); end
        end
    endtask

    task automatic test_narrow;
        wd[0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100; ws[0] = '1;
        axi_write(4'h2, 32'h00, 4'd0, 3'd4, 2'b01, -1, -1);
        for (int b = 0; b < 4; b++) begin
            wd[b] = {16{8'hEE}};
            wd[b][8*(b+1) +: 8] = 8'(8'hA1 + b);
            ws[b] = 16'(16'h0002 << b);
        end
        axi_write(4'h2, 32'h01, 4'd3, 3'd0, 2'b01, -1, -1);
        checks++;
        if (bresp_cap !== 2'b00) begin errors++; $display("FAIL narrow_bresp: got %b expected 00", bresp_cap); end
        axi_read(4'h2, 32'h00, 4'd0, 3'd4, 2'b01, 1'b0);
        checks++;
        if (rd[0] !== 128'h0f0e0d0c_0b0a0908_070605a4_a3a2a100) begin
            errors++; $display("FAIL narrow_word0: got %h expected 0f0e0d0c0b0a0908070605a4a3a2a100", rd[0]);
        end
    endtask

    task automatic test_errors;
        fill_words(32'h80, 32'h31);
        for (int b = 0; b < 4; b++) begin wd[b] = 128'hDEAD; ws[b] = '1; end
        axi_write(4'h4, 32'h80, 4'd3, 3'd4, 2'b11, -1, -1);
        checks++;
        if (bresp_cap !== 2'b10) begin errors++; $display("FAIL rsvd_bresp: got %b expected 10", bresp_cap); end
        wd[0] = 128'hBEEF;
        axi_write(4'h4, 32'h80, 4'd0, 3'd5, 2'b01, -1, -1);
        checks++;
        if (bresp_cap !== 2'b10) begin errors++; $display("FAIL size_bresp: got %b expected 10", bresp_cap); end
        axi_read(4'h4, 32'h80, 4'd3, 3'd4, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== 128'(32'h31 + b)) begin errors++; $display("FAIL illegal_nowrite[%0d]: got %h expected %h", b, rd[b], 128'(32'h31 + b)); end
        end
        axi_read(4'h9, 32'h80, 4'd3, 3'd4, 2'b11, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== 128'h0 || rr[b] !== 2'b10 || rl[b] !== (b == 3)) begin
                errors++; $display("FAIL rsvd_read[%0d]: got data=%h resp=%b last=%b expected data=0 resp=10 last=%b",
                                   b, rd[b], rr[b], rl[b], (b == 3));
            end
        end
        for (int b = 0; b < 4; b++) begin wd[b] = 128'(32'h41 + b); ws[b] = '1; end
        axi_write(4'h4, 32'h80, 4'd3, 3'd4, 2'b01, -1, 1);
        checks++;
        if (bresp_cap !== 2'b10) begin errors++; $display("FAIL wlast_bresp: got %b expected 10", bresp_cap); end
        axi_read(4'h4, 32'h80, 4'd3, 3'd4, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== 128'(32'h41 + b)) begin errors++; $display("FAIL wlast_written[%0d]: got %h expected %h", b, rd[b], 128'(32'h41 + b)); end
        end
        axi_write(4'h4, 32'h80, 4'd3, 3'd4, 2'b01, 2, -1);
        checks++;
        if (bresp_cap !== 2'b10) begin errors++; $display("FAIL wid_bresp: got %b expected 10", bresp_cap); end
    endtask

    task automatic test_concurrent;
        fill_words(32'h40, 32'h51);
        wd[0] = 128'h61; wd[1] = 128'h62; ws[0] = '1; ws[1] = '1;
        fork
            axi_write(4'h6, 32'h40, 4'd1, 3'd4, 2'b01, -1, -1);
            axi_read(4'h7, 32'h40, 4'd3, 3'd4, 2'b01, 1'b1);
        join
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd[b] !== 128'(32'h51 + b)) begin errors++; $display("FAIL conc_old[%0d]: got %h expected %h", b, rd[b], 128'(32'h51 + b)); end
        end
        checks++;
        if (stable_ok !== 1'b1) begin errors++; $display("FAIL conc_stall_stable: got %b expected 1", stable_ok); end
        checks++;
        if (bresp_cap !== 2'b00) begin errors++; $display("FAIL conc_bresp: got %b expected 00", bresp_cap); end
        axi_read(4'h7, 32'h40, 4'd1, 3'd4, 2'b01, 1'b0);
        checks++;
        if (rd[0] !== 128'h61 || rd[1] !== 128'h62) begin
            errors++; $display("FAIL conc_new: got %h %h expected 61 62", rd[0], rd[1]);
        end
    endtask

    task automatic test_reset_mid;
        fill_words(32'hC0, 32'h71);
        awid = 4'h2; awaddr = 32'hC0; awlen = 4'd3; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wid = 4'h2; wdata = 128'(32'h81 + b); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
            @(posedge aclk); #1;
        end
        wdata = 128'h83;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL mid_wready_before: got %b expected 1", wready); end
        areset_n = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            errors++; $display("FAIL mid_reset_flags: got %b expected 110000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if (bid !== 4'h0 || rdata !== 128'h0) begin errors++; $display("FAIL mid_reset_regs: got bid=%h rdata=%h expected 0 0", bid, rdata); end
        areset_n = 1'b1;
        wvalid = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL mid_awready_after: got %b expected 1", awready); end
        axi_read(4'h3, 32'hC0, 4'd3, 3'd4, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin
            logic [127:0] e;
            e = (b < 2) ? 128'(32'h81 + b) : 128'(32'h71 + b);
            checks++;
            if (rd[b] !== e) begin errors++; $display("FAIL mid_persist[%0d]: got %h expected %h", b, rd[b], e); end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_narrow();
        test_errors();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time limit expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/amba3_axi_mem_slave.md
# amba3_axi_mem_slave

Synthesizable AMBA 3 AXI slave backed by an on-chip word-addressed memory, parametrised in ID/address/data width and depth. It generalises the fixed-burst behavioural slave into RTL that supports FIXED, INCR and WRAP bursts, narrow transfers, byte strobes and protocol-error responses. Write and read channels run concurrently. It sits on the `amba3_axi_if` bus opposite `amba3_axi_master_t`, as the reference target for the VIP and as a scratch memory in SoC benches.

## Interface
- TXID_SIZE, 4, ID width
- ADDR_SIZE, 32, address width
- DATA_SIZE, 128, data width (8..1024, power of two)
- DEPTH_LOG2, 10, log2 of memory depth in DATA_SIZE words
- aclk  input  1  clock; all logic on rising edge
- areset_n  input  1  asynchronous active-low reset
- awid, awaddr, awlen, awsize, awburst  input  TXID_SIZE/ADDR_SIZE/4/3/2  write address
- awvalid input 1, awready output 1  AW handshake
- wid, wdata, wstrb, wlast, wvalid  input  TXID_SIZE/DATA_SIZE/DATA_SIZE/8/1/1  write data
- wready  output  1
- bid, bresp, bvalid  output  TXID_SIZE/2/1; bready input 1  write response
- arid, araddr, arlen, arsize, arburst, arvalid  input  as AW; arready output 1
- rid, rdata, rresp, rlast, rvalid  output  TXID_SIZE/DATA_SIZE/2/1/1; rready input 1

## Operation
- Word index = addr[LSB +: DEPTH_LOG2], LSB = log2(DATA_SIZE/8); upper address bits ignored (aliasing).
- Beat address: FIXED holds; INCR adds 2**size; WRAP adds 2**size within a (len+1)<<size aligned window.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE; AW latched on handshake. wready=1 only in W_DATA; each W handshake writes bytes with wstrb=1 and advances beat count. After beat len+1 -> W_RESP, bvalid=1, bid=latched awid; hold until bready.
- bresp=SLVERR (2'b10) if any of: awburst=2'b11; awsize > LSB; WRAP with len not in {1,3,7,15}; wid≠awid on any beat; wlast≠(beat==len) on any beat. Illegal burst/size/wrap: all beats accepted, no memory writes. ID/wlast errors: beats still written. Burst always ends on beat count, never on wlast. Otherwise OKAY.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. arready=1 only in R_IDLE. On AR handshake rdata loaded from first beat address; in R_DATA rvalid=1, rid=latched arid, rlast=(beat==len). On R handshake of non-last beat, next beat loaded same edge (no bubble). Same-class illegal AR -> len+1 beats, rdata=0, rresp=SLVERR.
- Write and read independent; same-cycle write and read of one word: read returns old data.

## Timing
- Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. Memory not reset; contents retained across reset, undefined after power-up.
- AW handshake edge N: awready=0, wready=1 from N+1. Last W at M: wready=0, bvalid=1 from M+1. B handshake at K: awready=1 from K+1. Min write turnaround len+3 cycles.
- AR handshake N: rvalid=1 from N+1; one beat per cycle with rready=1; last R at M: rvalid=0, arready=1 from M+1.
- Outputs stable while valid and not ready.
- Reset mid-burst: FSMs to idle immediately; partial writes already committed stay.

## Structure
- pkg_amba3: burst enum (FIXED/INCR/WRAP/RSVD), resp enum (OKAY/EXOKAY/SLVERR/DECERR), function for burst legality.
- Sub-module amba3_axi_burst_addr (addr, len, size, burst, beat-advance -> next addr, last, illegal flag), instantiated for write and read.
- Memory a flop/inferred array, DATA_SIZE x 2**DEPTH_LOG2, byte-enable write.

## Test plan
- INCR len=3 size=4 write 0x10 data 0x11..0x14 strobes all 1, read back -> B OKAY, R 0x11,0x12,0x13,0x14, rlast on beat 3 only.
- WRAP len=3 size=4 write at 0x28 -> words written 0x28,0x2C? no: 0x28,0x38,0x08,0x18 (64-byte window 0x00-0x3F at size 4), read back INCR from 0x00 matches order.
- Narrow INCR size=0 len=3 at 0x01 wstrb 0x0002,0x0004,0x0008,0x0010 -> bytes 1..4 of word 0 updated, others unchanged.
- awburst=2'b11 and separately wlast high on beat 1 of len=3 -> SLVERR; first no memory change, second all 4 beats written.
- Concurrent write 0x40 and read 0x40 with rready toggling 1/0 -> read returns pre-write data, no beat lost, rdata stable while stalled.
- Reset asserted during W_DATA beat 2 -> all outputs at reset values next cycle, awready=1 after release, beats 0-1 persist.
